// File: rtl/memory_game_ctrl.sv
// Memory Matrix round sequencer: fetch a board, show it, score guesses, end in WIN/LOSE.
// Optional PLAY idle timeout is compiled in when MM_TIMEOUT_EN is defined.
module memory_game_ctrl #(
    parameter int N_TILES      = 16,
    parameter int SHOW_CYCLES  = 100,
    parameter int MAX_MISSES   = 3,
    parameter int PLAY_TIMEOUT = 1000,
    localparam int IDXW = $clog2(N_TILES),
    localparam int MW   = $clog2(MAX_MISSES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_TILES-1:0] board,
    output logic               ld_board,
    input  logic               guess_valid,
    input  logic [IDXW-1:0]    guess_idx,
    output logic               show,
    output logic [N_TILES-1:0] display,
    output logic [N_TILES-1:0] revealed,
    output logic [MW-1:0]      misses,
    output logic               win,
    output logic               lose,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GEN     = 3'd1,
        S_CAPTURE = 3'd2,
        S_SHOW    = 3'd3,
        S_PLAY    = 3'd4,
        S_WIN     = 3'd5,
        S_LOSE    = 3'd6
    } state_e;

    localparam int            TW        = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [MW-1:0] MISS_LIM  = MW'(MAX_MISSES);

    state_e             state_q;
    logic [N_TILES-1:0] target_q;
    logic [N_TILES-1:0] revealed_q, revealed_d;
    logic [MW-1:0]      misses_q, misses_d;
    logic [TW-1:0]      timer_q;
    logic               start_q;
    logic               ld_board_q, show_q, win_q, lose_q;
    logic               start_edge;
    logic               timeout_hit;

    assign start_edge = start & ~start_q;

    // Score the current guess; only committed when a guess is taken in PLAY.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        revealed_d = revealed_q;
        misses_d   = misses_q;
        if (target_q[guess_idx]) begin
            revealed_d = revealed_q | (N_TILES'(1) << guess_idx);
        end else if (misses_q != MISS_LIM) begin
            misses_d = misses_q + 1'b1;
        end
    end

`ifdef MM_TIMEOUT_EN
    localparam int            IW        = (PLAY_TIMEOUT > 1) ? $clog2(PLAY_TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(PLAY_TIMEOUT - 1);

    logic [IW-1:0] idle_q;

    // Idle counter is held at zero outside PLAY, so entering PLAY starts it fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else if (state_q == S_PLAY && !guess_valid) begin
            idle_q <= idle_q + 1'b1;
        end else begin
            idle_q <= '0;
        end
    end

    assign timeout_hit = (idle_q == IDLE_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            revealed_q <= '0;
            misses_q   <= '0;
            timer_q    <= '0;
            start_q    <= 1'b0;
            ld_board_q <= 1'b0;
            show_q     <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            start_q    <= start;
            ld_board_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start_edge) begin
                        state_q    <= S_GEN;
                        ld_board_q <= 1'b1;
                        revealed_q <= '0;
                        misses_q   <= '0;
                        win_q      <= 1'b0;
                        lose_q     <= 1'b0;
                    end
                end
                S_GEN: state_q <= S_CAPTURE;
                S_CAPTURE: begin
                    target_q <= board;
                    if (board == '0) begin
                        state_q    <= S_GEN;
                        ld_board_q <= 1'b1;
                    end else begin
                        state_q <= S_SHOW;
                        timer_q <= SHOW_LOAD;
                        show_q  <= 1'b1;
                    end
                end
                S_SHOW: begin
                    if (timer_q == '0) begin
                        state_q <= S_PLAY;
                        show_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_PLAY: begin
                    if (guess_valid) begin
                        revealed_q <= revealed_d;
                        misses_q   <= misses_d;
                        if (revealed_d == target_q) begin
                            state_q <= S_WIN;
                            win_q   <= 1'b1;
                        end else if (misses_d == MISS_LIM) begin
                            state_q <= S_LOSE;
                            lose_q  <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_q <= S_LOSE;
                        lose_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // LOSE shows the answer; PLAY and WIN show what the player has found.
    always_comb begin
        display = '0;
        case (state_q)
            S_SHOW, S_LOSE: display = target_q;
            S_PLAY, S_WIN:  display = revealed_q;
            default:        display = '0;
        endcase
    end

    assign ld_board = ld_board_q;
    assign show     = show_q;
    assign revealed = revealed_q;
    assign misses   = misses_q;
    assign win      = win_q;
    assign lose     = lose_q;
    assign state    = state_q;

endmodule

// File: doc/memory_game_ctrl.md
# memory_game_ctrl

Top-level sequencer for the Memory Matrix game. It requests a pseudo-random board from the board datapath and shows that pattern for a fixed time, then hides it. It then scores the player's tile selections against the pattern and ends the round in WIN or LOSE. It sits between the user inputs (start key, tile selector) and the board datapath/display.

## Interface
- `N_TILES`, default 16: board size in tiles; must be a power of two, ≥4.
- `SHOW_CYCLES`, default 100: number of cycles the pattern is displayed.
- `MAX_MISSES`, default 3: number of wrong guesses that end the round.
- `PLAY_TIMEOUT`, default 1000: number of idle cycles in PLAY before a loss. Used only with `MM_TIMEOUT_EN`.
- `IDXW`: localparam, equal to clog2(N_TILES).
- `MW`: localparam, equal to clog2(MAX_MISSES+1).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low; resets the whole block.
- `start`  in  1  start level; only its rising edge (registered `start_q`) acts.
- `board`  in  N_TILES  board from the datapath; valid the cycle after `ld_board`.
- `ld_board`  out  1  one-cycle request to the datapath to load a new random board.
- `guess_valid`  in  1  one-cycle pulse that qualifies `guess_idx`.
- `guess_idx`  in  IDXW  index of the tile the player selected.
- `show`  out  1  high while the pattern is displayed.
- `display`  out  N_TILES  tile mask for the LEDs.
- `revealed`  out  N_TILES  correctly found tiles.
- `misses`  out  MW  wrong-guess count.
- `win`, `lose`  out  1  round result, each held until the next round.
- `state`  out  3  current state, for debug.

## Operation
State encoding: IDLE=0, GEN=1, CAPTURE=2, SHOW=3, PLAY=4, WIN=5, LOSE=6.

Transitions:
- IDLE → GEN on a start edge.
- GEN: `ld_board`=1 for one cycle, then → CAPTURE.
- CAPTURE: `target` <= `board`.
  - If `board`==0, go back to GEN (regenerate).
  - Otherwise load the timer with SHOW_CYCLES−1 and go to SHOW.
- SHOW: `show`=1. The timer decrements each cycle. When the timer is 0, go to PLAY.
- PLAY: each `guess_valid` is scored as follows.
  - Tile in `target` and not yet revealed: set its `revealed` bit.
  - Tile already revealed: no effect.
  - Tile not in `target`: `misses`+1. The counter saturates at MAX_MISSES.
  - After the update: `revealed`==`target` → WIN; `misses`==MAX_MISSES → LOSE. One guess cannot cause both.
- WIN/LOSE: hold all outputs. A start edge → GEN, clearing `revealed`, `misses`, `win` and `lose` on entry to GEN.
- A start edge outside IDLE/WIN/LOSE is ignored.
- `guess_valid` outside PLAY is ignored.

`display` is combinational from registered state:
- SHOW: `target`.
- PLAY and WIN: `revealed`.
- LOSE: `target`, so the answer is shown.
- All other states: 0.

`win`=1 only in WIN; `lose`=1 only in LOSE.

## Timing
- Reset (async assert, synchronous release): state=IDLE. `ld_board`, `show`, `display`, `revealed`, `misses`, `win`, `lose`, `target`, timer and `start_q` are all 0.
- Reset asserted mid-round aborts immediately; no output glitch survives past the reset edge.
- Start edge sampled at cycle k:
  - GEN at k+1, with `ld_board` high during k+1.
  - CAPTURE at k+2.
  - SHOW during cycles k+3 … k+2+SHOW_CYCLES.
  - PLAY from k+3+SHOW_CYCLES.
- Guess sampled at cycle g: `revealed`/`misses` update at g+1, and WIN/LOSE is entered at g+1.
- A board of 0 adds 2 cycles per retry.
- Back-to-back `guess_valid` pulses are accepted every cycle.

## Configuration
- `MM_TIMEOUT_EN` defined: an idle counter runs in PLAY.
  - It is cleared on entry to PLAY and on every `guess_valid`.
  - When it reaches PLAY_TIMEOUT−1 with no guess, the next state is LOSE.
  - A guess in that same cycle takes priority.
- `MM_TIMEOUT_EN` undefined: there is no counter, and PLAY waits indefinitely.

## Test plan
- Reset released, no start → state=0, and every output is 0 for 50 cycles.
- Start edge at cycle 10, `board`=16'h00A5 returned, SHOW_CYCLES=100 → `ld_board` is high only at cycle 11; `show` is high for cycles 13–112; `display`=16'h00A5; PLAY at 113.
- In PLAY with `target`=16'h00A5, guesses 0,2,5,7, with 2 repeated once → `revealed` grows to 16'h00A5, `misses`=0, and `win`=1 one cycle after guess 7.
- Guesses 1,3,4 against 16'h00A5 → `misses`=1,2,3, then LOSE with `display`=16'h00A5. A start edge then gives GEN with `misses`=0.
- Datapath returns 0 twice, then 16'h0001 → GEN/CAPTURE repeat twice before SHOW; reset pulsed during SHOW → IDLE and all outputs 0 immediately.
- With `MM_TIMEOUT_EN` and PLAY_TIMEOUT=20: no guesses → LOSE exactly 20 cycles after PLAY entry. A guess at cycle 15 restarts the count.
